// File: rtl/uart_pkg.sv
// Shared constants, state encoding and parity helper for the configurable UART.
package uart_pkg;

  // Parity modes
  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Ticks per bit period
  localparam int unsigned OVERSAMPLE = 16;

  // Widest supported data word; the parity helper works on words padded to this width
  localparam int unsigned MAX_DBIT = 9;

  // Common TX/RX state encoding. The parity state is PARITY_BIT so it cannot collide with
  // the PARITY parameter of uart_cfg.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY_BIT,
    STOP
  } uart_state_e;

  // Parity bit to transmit (or expect) for a zero-padded data word
  function automatic logic calc_parity(input logic [MAX_DBIT-1:0] data, input int unsigned mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one tick every dvsr+1 clocks.
module uart_baud_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] dvsr,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Wrap on >= so lowering dvsr below the current count cannot strand the counter
  always_comb begin
    tick  = (cnt_q >= dvsr);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Divisor counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cfg.sv
// Configurable UART: runtime divisor, 5..9 data bits, optional parity, RX holding register
// with valid/ack handshake and parity/framing/overrun reporting.
module uart_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned PARITY  = PAR_NONE,
  parameter int unsigned SB_TICK = 16,
  parameter int unsigned DIV_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] dvsr,
  input  logic             data_in,
  output logic             data_out,
  input  logic             tx_start,
  input  logic [DBIT-1:0]  w_data,
  output logic             tx_ready,
  output logic             tx_done_tick,
  output logic [DBIT-1:0]  r_data,
  output logic             rx_valid,
  input  logic             rx_ack,
  output logic             rx_done_tick,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun_err,
  input  logic             err_clr
);

  // RX STOP runs from the last mid-bit sample, so it needs half a bit more than SB_TICK
  localparam int unsigned SW = $clog2(SB_TICK + OVERSAMPLE / 2);
  localparam int unsigned NW = $clog2(DBIT);

  localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_TX_STOP = SW'(SB_TICK - 1);
  localparam logic [SW-1:0] S_RX_STOP = SW'(SB_TICK + OVERSAMPLE / 2 - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);
  localparam logic          HAS_PAR   = (PARITY != PAR_NONE);

  logic tick;

  uart_baud_tick #(
    .DIV_W(DIV_W)
  ) u_baud_tick (
    .clk  (clk),
    .reset(reset),
    .dvsr (dvsr),
    .tick (tick)
  );

  // ---------------------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------------------
  uart_state_e     tx_state_q, tx_state_d;
  logic [SW-1:0]   tx_s_q, tx_s_d;
  logic [NW-1:0]   tx_n_q, tx_n_d;
  logic [DBIT-1:0] tx_b_q, tx_b_d;
  logic            tx_par_q, tx_par_d;
  logic            tx_q, tx_d;
  logic            tx_ready_q, tx_ready_d;
  logic            tx_done_q, tx_done_d;
  logic            tx_fin;

  // TX state and datapath registers; idle line is high and the transmitter is ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= IDLE;
      tx_s_q     <= '0;
      tx_n_q     <= '0;
      tx_b_q     <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_s_q     <= tx_s_d;
      tx_n_q     <= tx_n_d;
      tx_b_q     <= tx_b_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      tx_ready_q <= tx_ready_d;
      tx_done_q  <= tx_done_d;
    end
  end

  // TX next-state: word and its parity are captured on acceptance, then shifted out LSB first
  always_comb begin
    tx_state_d = tx_state_q;
    tx_s_d     = tx_s_q;
    tx_n_d     = tx_n_q;
    tx_b_d     = tx_b_q;
    tx_par_d   = tx_par_q;
    tx_fin     = 1'b0;
    unique case (tx_state_q)
      IDLE: begin
        if (tx_start) begin
          tx_state_d = START;
          tx_s_d     = '0;
          tx_b_d     = w_data;
          tx_par_d   = calc_parity(MAX_DBIT'(w_data), PARITY);
        end
      end
      START: begin
        if (tick) begin
          if (tx_s_q == S_LAST) begin
            tx_state_d = DATA;
            tx_s_d     = '0;
            tx_n_d     = '0;
          end else begin
            tx_s_d = tx_s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tx_s_q == S_LAST) begin
            tx_s_d = '0;
            tx_b_d = tx_b_q >> 1;
            if (tx_n_q == N_LAST) begin
              tx_state_d = HAS_PAR ? PARITY_BIT : STOP;
            end else begin
              tx_n_d = tx_n_q + 1'b1;
            end
          end else begin
            tx_s_d = tx_s_q + 1'b1;
          end
        end
      end
      PARITY_BIT: begin
        if (tick) begin
          if (tx_s_q == S_LAST) begin
            tx_state_d = STOP;
            tx_s_d     = '0;
          end else begin
            tx_s_d = tx_s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tx_s_q == S_TX_STOP) begin
            tx_state_d = IDLE;
            tx_fin     = 1'b1;
          end else begin
            tx_s_d = tx_s_q + 1'b1;
          end
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

  // TX outputs are decoded from the next state so the line register changes with the state
  always_comb begin
    case (tx_state_d)
      START:      tx_d = 1'b0;
      DATA:       tx_d = tx_b_d[0];
      PARITY_BIT: tx_d = tx_par_d;
      default:    tx_d = 1'b1;
    endcase
    tx_ready_d = (tx_state_d == IDLE);
    tx_done_d  = tx_fin;
  end

  assign data_out     = tx_q;
  assign tx_ready     = tx_ready_q;
  assign tx_done_tick = tx_done_q;

  // ---------------------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------------------
  logic [1:0]      sync_q;
  logic            rx_bit;
  uart_state_e     rx_state_q, rx_state_d;
  logic [SW-1:0]   rx_s_q, rx_s_d;
  logic [NW-1:0]   rx_n_q, rx_n_d;
  logic [DBIT-1:0] rx_b_q, rx_b_d;
  logic            rx_par_q, rx_par_d;
  logic            rx_stop_q, rx_stop_d;
  logic            rx_done_q, rx_done_d;
  logic            rx_fin;

  assign rx_bit = sync_q[1];

  // Synchroniser (presets to idle-high) and RX state/datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= 2'b11;
      rx_state_q <= IDLE;
      rx_s_q     <= '0;
      rx_n_q     <= '0;
      rx_b_q     <= '0;
      rx_par_q   <= 1'b0;
      rx_stop_q  <= 1'b1;
      rx_done_q  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], data_in};
      rx_state_q <= rx_state_d;
      rx_s_q     <= rx_s_d;
      rx_n_q     <= rx_n_d;
      rx_b_q     <= rx_b_d;
      rx_par_q   <= rx_par_d;
      rx_stop_q  <= rx_stop_d;
      rx_done_q  <= rx_done_d;
    end
  end

  // RX next-state: recheck the start bit at its middle, then sample every bit period
  always_comb begin
    rx_state_d = rx_state_q;
    rx_s_d     = rx_s_q;
    rx_n_d     = rx_n_q;
    rx_b_d     = rx_b_q;
    rx_par_d   = rx_par_q;
    rx_stop_d  = rx_stop_q;
    rx_fin     = 1'b0;
    unique case (rx_state_q)
      IDLE: begin
        if (!rx_bit) begin
          rx_state_d = START;
          rx_s_d     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (rx_s_q == S_MID) begin
            // A line back high at mid start bit is a glitch, not a frame
            rx_state_d = rx_bit ? IDLE : DATA;
            rx_s_d     = '0;
            rx_n_d     = '0;
          end else begin
            rx_s_d = rx_s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (rx_s_q == S_LAST) begin
            rx_s_d = '0;
            rx_b_d = {rx_bit, rx_b_q[DBIT-1:1]};
            if (rx_n_q == N_LAST) begin
              rx_state_d = HAS_PAR ? PARITY_BIT : STOP;
            end else begin
              rx_n_d = rx_n_q + 1'b1;
            end
          end else begin
            rx_s_d = rx_s_q + 1'b1;
          end
        end
      end
      PARITY_BIT: begin
        if (tick) begin
          if (rx_s_q == S_LAST) begin
            rx_state_d = STOP;
            rx_s_d     = '0;
            rx_par_d   = rx_bit;
          end else begin
            rx_s_d = rx_s_q + 1'b1;
          end
        end
      end
      STOP: begin
        // Sample the stop bit one period after the last sample; finish at the frame's end
        if (tick) begin
          if (rx_s_q == S_RX_STOP) begin
            rx_state_d = IDLE;
            rx_fin     = 1'b1;
          end else begin
            rx_s_d = rx_s_q + 1'b1;
            if (rx_s_q == S_LAST) begin
              rx_stop_d = rx_bit;
            end
          end
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  // RX output: done pulse registered from the final STOP tick
  always_comb begin
    rx_done_d = rx_fin;
  end

  assign rx_done_tick = rx_done_q;

  // ---------------------------------------------------------------------------------------
  // Holding register
  // ---------------------------------------------------------------------------------------
  logic [DBIT-1:0] r_data_q, r_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            parity_err_q, parity_err_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            load, drop;

  // Load a completed frame unless the previous one is still unconsumed
  always_comb begin
    load         = rx_done_q & (~rx_valid_q | rx_ack);
    drop         = rx_done_q & rx_valid_q & ~rx_ack;
    r_data_d     = load ? rx_b_q : r_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    if (load) begin
      parity_err_d = HAS_PAR & (calc_parity(MAX_DBIT'(rx_b_q), PARITY) != rx_par_q);
      frame_err_d  = ~rx_stop_q;
    end
    rx_valid_d = load | (rx_valid_q & ~rx_ack);
    // A new overrun beats a simultaneous clear
    overrun_d  = drop | (overrun_q & ~err_clr);
  end

  // Holding register and error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_q     <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      r_data_q     <= r_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign r_data      = r_data_q;
  assign rx_valid    = rx_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;

endmodule

// File: tb/tb_uart_cfg.sv
// Bench for uart_cfg: even-parity instance in loopback, odd-parity instance driven directly.
module tb_uart_cfg;

  localparam int DVSR     = 3;
  localparam int TICK_CLK = DVSR + 1;
  localparam int BIT_CLK  = 16 * TICK_CLK;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] dvsr;
  logic        loop_en, drv_e, drv_o;

  logic       data_in_e, data_out_e, tx_start_e, tx_ready_e, tx_done_e;
  logic       rx_valid_e, rx_ack_e, rx_done_e, perr_e, ferr_e, ovr_e, err_clr_e;
  logic [7:0] w_data_e, r_data_e;

  logic       data_in_o, data_out_o, tx_start_o, tx_ready_o, tx_done_o;
  logic       rx_valid_o, rx_ack_o, rx_done_o, perr_o, ferr_o, ovr_o, err_clr_o;
  logic [7:0] w_data_o, r_data_o;

  int checks   = 0;
  int failures = 0;

  assign data_in_e = loop_en ? data_out_e : drv_e;
  assign data_in_o = drv_o;

  always #5 clk = ~clk;

  uart_cfg #(.DBIT(8), .PARITY(1), .SB_TICK(16), .DIV_W(16)) u_even (
    .clk(clk), .reset(reset), .dvsr(dvsr), .data_in(data_in_e), .data_out(data_out_e),
    .tx_start(tx_start_e), .w_data(w_data_e), .tx_ready(tx_ready_e), .tx_done_tick(tx_done_e),
    .r_data(r_data_e), .rx_valid(rx_valid_e), .rx_ack(rx_ack_e), .rx_done_tick(rx_done_e),
    .parity_err(perr_e), .frame_err(ferr_e), .overrun_err(ovr_e), .err_clr(err_clr_e)
  );

  uart_cfg #(.DBIT(8), .PARITY(2), .SB_TICK(16), .DIV_W(16)) u_odd (
    .clk(clk), .reset(reset), .dvsr(dvsr), .data_in(data_in_o), .data_out(data_out_o),
    .tx_start(tx_start_o), .w_data(w_data_o), .tx_ready(tx_ready_o), .tx_done_tick(tx_done_o),
    .r_data(r_data_o), .rx_valid(rx_valid_o), .rx_ack(rx_ack_o), .rx_done_tick(rx_done_o),
    .parity_err(perr_o), .frame_err(ferr_o), .overrun_err(ovr_o), .err_clr(err_clr_o)
  );

  // Reference frame: index 0 = start bit, 1..8 = data LSB first, 9 = parity, 10 = stop
  function automatic logic [10:0] model_frame(input logic [7:0] d, input int mode);
    logic p;
    p = ($countones(d) % 2) == 1;
    if (mode == 2) p = !p;
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one frame onto the odd instance's RX line, optionally corrupting parity/stop
  task automatic drive_frame(input logic [7:0] d, input bit flip, input bit stp);
    logic [10:0] f;
    f     = model_frame(d, 2);
    f[9]  = f[9] ^ flip;
    f[10] = stp;
    for (int i = 0; i < 11; i++) begin
      drv_o = f[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    drv_o = 1'b1;
  endtask

  // Wait (bounded) for rx_done on the odd instance; apply ack/clr in that same cycle
  task automatic wait_rx(input bit ack, input bit clr, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (rx_done_o === 1'b1) begin
        seen      = 1'b1;
        rx_ack_o  = ack;
        err_clr_o = clr;
      end
    end
    @(negedge clk);
    rx_ack_o  = 1'b0;
    err_clr_o = 1'b0;
    check($sformatf("%s_rx_done_seen", tag), 32'(seen), 1);
  endtask

  task automatic odd_frame(input logic [7:0] d, input bit flip, input bit stp,
                           input bit ack, input bit clr, input string tag);
    drive_frame(d, flip, stp);
    wait_rx(ack, clr, tag);
  endtask

  task automatic pulse_odd(input bit ack, input bit clr);
    rx_ack_o  = ack;
    err_clr_o = clr;
    @(negedge clk);
    rx_ack_o  = 1'b0;
    err_clr_o = 1'b0;
  endtask

  // Loopback transfer on the even instance, checking line bits, timing and the received word
  task automatic loop_send(input logic [7:0] d, input bit busy_poke, input string tag);
    logic [10:0] f;
    int off, t_tx, t_rx;
    f = model_frame(d, 1);
    w_data_e   = d;
    tx_start_e = 1'b1;
    @(negedge clk);
    tx_start_e = 1'b0;
    off = 1;
    check($sformatf("%s_line_fall", tag), 32'(data_out_e), 0);
    check($sformatf("%s_ready_drop", tag), 32'(tx_ready_e), 0);
    repeat (32) @(negedge clk);
    off += 32;
    for (int i = 0; i < 11; i++) begin
      check($sformatf("%s_bit%0d", tag, i), 32'(data_out_e), 32'(f[i]));
      if (i < 10) begin
        if (busy_poke && i == 0) begin
          w_data_e   = ~d;
          tx_start_e = 1'b1;
          @(negedge clk);
          tx_start_e = 1'b0;
          repeat (BIT_CLK - 1) @(negedge clk);
        end else begin
          repeat (BIT_CLK) @(negedge clk);
        end
        off += BIT_CLK;
      end
    end
    t_tx = -1;
    t_rx = -1;
    for (int i = 0; i < 200 && t_rx < 0; i++) begin
      @(negedge clk);
      off++;
      if (tx_done_e === 1'b1) begin
        t_tx = off;
        check($sformatf("%s_ready_with_done", tag), 32'(tx_ready_e), 1);
      end
      if (rx_done_e === 1'b1) t_rx = off;
    end
    check($sformatf("%s_tx_done_seen", tag), 32'(t_tx >= 0), 1);
    // 176 ticks of 4 clocks, plus synchroniser latency and tick phase
    check($sformatf("%s_rx_latency_%0d", tag, t_rx), 32'(t_rx >= 704 && t_rx <= 712), 1);
    @(negedge clk);
    check($sformatf("%s_r_data", tag), 32'(r_data_e), 32'(d));
    check($sformatf("%s_rx_valid", tag), 32'(rx_valid_e), 1);
    check($sformatf("%s_parity_err", tag), 32'(perr_e), 0);
    check($sformatf("%s_frame_err", tag), 32'(ferr_e), 0);
    check($sformatf("%s_no_ghost_frame", tag), 32'(tx_ready_e), 1);
    rx_ack_e = 1'b1;
    @(negedge clk);
    rx_ack_e = 1'b0;
    check($sformatf("%s_ack_clears_valid", tag), 32'(rx_valid_e), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  d;
    logic [10:0] f;
    bit          flip, stp;
    int          pulses;

    reset = 1'b1;
    dvsr  = 16'(DVSR);
    loop_en = 1'b1;
    drv_e = 1'b1;
    drv_o = 1'b1;
    tx_start_e = 1'b0; w_data_e = '0; rx_ack_e = 1'b0; err_clr_e = 1'b0;
    tx_start_o = 1'b0; w_data_o = '0; rx_ack_o = 1'b0; err_clr_o = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_out", 32'(data_out_e), 1);
    check("rst_tx_ready", 32'(tx_ready_e), 1);
    check("rst_rx_valid", 32'(rx_valid_e), 0);
    check("rst_r_data", 32'(r_data_o), 0);
    check("rst_overrun", 32'(ovr_o), 0);
    check("rst_tx_done", 32'(tx_done_e), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_rx_done", 32'(rx_done_e), 0);
    check("idle_data_out", 32'(data_out_o), 1);

    // Loopback: directed 0xA5 (with an ignored start while busy), then random words
    loop_send(8'hA5, 1'b1, "lb_a5");
    for (int k = 0; k < 3; k++) begin
      d = 8'($urandom_range(0, 255));
      loop_send(d, 1'b0, $sformatf("lb_rand%0d", k));
    end

    // Odd parity: wrong parity bit
    odd_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, "odd_3c");
    check("odd_3c_r_data", 32'(r_data_o), 32'h3C);
    check("odd_3c_parity_err", 32'(perr_o), 1);
    check("odd_3c_frame_err", 32'(ferr_o), 0);
    pulse_odd(1'b1, 1'b0);
    check("odd_3c_popped", 32'(rx_valid_o), 0);

    // Stop bit low
    odd_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, "odd_81");
    check("odd_81_r_data", 32'(r_data_o), 32'h81);
    check("odd_81_frame_err", 32'(ferr_o), 1);
    check("odd_81_parity_err", 32'(perr_o), 0);
    check("odd_81_rx_valid", 32'(rx_valid_o), 1);
    pulse_odd(1'b1, 1'b0);
    repeat (BIT_CLK) @(negedge clk);

    // Random words with random parity/stop corruption
    for (int k = 0; k < 4; k++) begin
      d    = 8'($urandom_range(0, 255));
      flip = 1'($urandom_range(0, 1));
      stp  = 1'($urandom_range(0, 1));
      odd_frame(d, flip, stp, 1'b0, 1'b0, $sformatf("odd_rand%0d", k));
      check($sformatf("odd_rand%0d_r_data", k), 32'(r_data_o), 32'(d));
      check($sformatf("odd_rand%0d_parity_err", k), 32'(perr_o), 32'(flip));
      check($sformatf("odd_rand%0d_frame_err", k), 32'(ferr_o), 32'(!stp));
      pulse_odd(1'b1, 1'b0);
      repeat (BIT_CLK) @(negedge clk);
    end

    // Overrun: second frame dropped while the first is unconsumed
    odd_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, "ovr_11");
    check("ovr_11_no_overrun", 32'(ovr_o), 0);
    odd_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0, "ovr_22");
    check("ovr_keeps_old", 32'(r_data_o), 32'h11);
    check("ovr_set", 32'(ovr_o), 1);
    check("ovr_valid", 32'(rx_valid_o), 1);
    pulse_odd(1'b0, 1'b1);
    check("ovr_cleared", 32'(ovr_o), 0);
    check("ovr_clr_keeps_data", 32'(r_data_o), 32'h11);
    // Overrun in the same cycle as err_clr: flag stays set
    odd_frame(8'h44, 1'b0, 1'b1, 1'b0, 1'b1, "ovr_44");
    check("ovr_beats_clr", 32'(ovr_o), 1);
    check("ovr_44_keeps_old", 32'(r_data_o), 32'h11);
    pulse_odd(1'b0, 1'b1);
    // Ack together with rx_done: new word accepted, no overrun
    odd_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b0, "ack_22");
    check("ack_22_r_data", 32'(r_data_o), 32'h22);
    check("ack_22_no_overrun", 32'(ovr_o), 0);
    check("ack_22_valid", 32'(rx_valid_o), 1);
    pulse_odd(1'b1, 1'b0);
    check("ack_alone_clears", 32'(rx_valid_o), 0);
    pulse_odd(1'b1, 1'b0);
    check("ack_empty_valid", 32'(rx_valid_o), 0);
    check("ack_empty_data", 32'(r_data_o), 32'h22);

    // Glitch on idle RX line: 4 ticks low must not produce a frame
    loop_en = 1'b0;
    drv_e   = 1'b0;
    repeat (4 * TICK_CLK) @(negedge clk);
    drv_e  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12 * BIT_CLK; i++) begin
      @(negedge clk);
      if (rx_done_e === 1'b1) pulses++;
    end
    check("glitch_no_done", 32'(pulses), 0);
    check("glitch_no_valid", 32'(rx_valid_e), 0);
    loop_en = 1'b1;

    // Reset in the middle of data bit 3
    f = model_frame(8'hA5, 1);
    w_data_e   = 8'hA5;
    tx_start_e = 1'b1;
    @(negedge clk);
    tx_start_e = 1'b0;
    repeat (288) @(negedge clk);
    check("pre_rst_bit3", 32'(data_out_e), 32'(f[4]));
    #1 reset = 1'b1;
    #1;
    check("mid_rst_data_out", 32'(data_out_e), 1);
    check("mid_rst_tx_ready", 32'(tx_ready_e), 1);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3 * BIT_CLK; i++) begin
      @(negedge clk);
      if (rx_done_e === 1'b1 || tx_done_e === 1'b1) pulses++;
    end
    check("mid_rst_no_done", 32'(pulses), 0);
    check("mid_rst_rx_valid", 32'(rx_valid_e), 0);
    loop_send(8'h5A, 1'b0, "post_rst_5a");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
